// File: rtl/icon_utree_pipe_if.sv
// icon_utree_pipe bus bundle: per-lane beat inputs, per-channel outputs,
// sink readiness and the drop counter, with source/sink and pipe views.
interface icon_utree_pipe_if #(
    parameter int CHANS  = 4,
    parameter int RATIO  = 4,
    parameter int DATA_W = 7,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    localparam int INPUTS = RATIO * CHANS;
    localparam int NODES  = INPUTS / 2;
    localparam int STAGES = $clog2(INPUTS);

    logic [INPUTS-1:0]              i_valid;
    logic [INPUTS-1:0][ADDR_W-1:0]  i_addr;
    logic [INPUTS-1:0][DATA_W-1:0]  i_data;
    logic [STAGES-1:0][NODES-1:0]   i_scb;
    logic                           o_in_ready;
    logic [CHANS-1:0]               o_valid;
    logic [CHANS-1:0][ADDR_W-1:0]   o_addr;
    logic [CHANS-1:0][DATA_W-1:0]   o_data;
    logic [STAGES-1:0][NODES-1:0]   o_scb;
    logic [CHANS-1:0]               i_out_ready;
    logic [CNT_W-1:0]               o_drop_cnt;

    modport master (
        output i_valid, i_addr, i_data, i_scb, i_out_ready,
        input  o_in_ready, o_valid, o_addr, o_data, o_scb, o_drop_cnt
    );

    modport slave (
        input  i_valid, i_addr, i_data, i_scb, i_out_ready,
        output o_in_ready, o_valid, o_addr, o_data, o_scb, o_drop_cnt
    );
endinterface

// File: rtl/icon_utree_pipe.sv
// icon_utree_pipe: butterfly concentration tree with optional per-stage
// registers, per-lane valids, beat-carried switch words and drop counting.
module icon_utree_pipe #(
    parameter int          CHANS     = 4,
    parameter int          RATIO     = 4,
    parameter int          DATA_W    = 7,
    parameter int          ADDR_W    = 8,
    parameter int unsigned PIPE_MASK = 0,
    parameter int          CNT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    icon_utree_pipe_if.slave  bus
);
    function automatic int popcount(input int unsigned x);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c += int'(x[i]);
        end
        return c;
    endfunction

    localparam int INPUTS = RATIO * CHANS;
    localparam int NODES  = INPUTS / 2;
    localparam int STAGES = $clog2(INPUTS);
    localparam int LAT    = popcount(PIPE_MASK);
    localparam int SUM_W  = CNT_W + $clog2(INPUTS + 1);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
        $error("icon_utree_pipe: RATIO must be a power of 2 and >= 2");
    end

    if (LAT > STAGES || (PIPE_MASK >> STAGES) != 0) begin : g_bad_mask
        $error("icon_utree_pipe: PIPE_MASK has bits beyond STAGES");
    end

    typedef logic [INPUTS-1:0]             vec_t;
    typedef logic [INPUTS-1:0][ADDR_W-1:0] addr_t;
    typedef logic [INPUTS-1:0][DATA_W-1:0] data_t;
    typedef logic [STAGES-1:0][NODES-1:0]  scb_t;

    vec_t   v_d   [STAGES];
    vec_t   v_q   [STAGES];
    addr_t  a_d   [STAGES];
    addr_t  a_q   [STAGES];
    data_t  d_d   [STAGES];
    data_t  d_q   [STAGES];
    scb_t   scb_d [STAGES];
    scb_t   scb_q [STAGES];

    logic             stall;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Walk the beat from the top stage down to stage 0, switching each
    // pair by its own control bit and picking registered or live values.
    always_comb begin
        vec_t             cv;
        vec_t             nv;
        addr_t            ca;
        addr_t            na;
        data_t            cd;
        data_t            nd;
        scb_t             cs;
        logic [CHANS-1:0] ov;
        logic [SUM_W-1:0] drops;
        logic [SUM_W-1:0] sum;
        int               lo;
        int               hi;

        cv = bus.i_valid;
        ca = bus.i_addr;
        cd = bus.i_data;
        cs = bus.i_scb;
        nv = '0;
        na = '0;
        nd = '0;
        lo = 0;
        hi = 0;

        for (int s = STAGES - 1; s >= 0; s--) begin
            nv = cv;
            na = ca;
            nd = cd;
            for (int n = 0; n < NODES; n++) begin
                lo = ((n >> s) << (s + 1)) | (n & ((1 << s) - 1));
                hi = lo + (1 << s);
                if (cs[s][n]) begin
                    nv[lo] = cv[hi];
                    nv[hi] = cv[lo];
                    na[lo] = ca[hi];
                    na[hi] = ca[lo];
                    nd[lo] = cd[hi];
                    nd[hi] = cd[lo];
                end
            end
            v_d[s]   = nv;
            a_d[s]   = na;
            d_d[s]   = nd;
            scb_d[s] = cs;
            if (PIPE_MASK[s]) begin
                cv = v_q[s];
                ca = a_q[s];
                cd = d_q[s];
                cs = scb_q[s];
            end else begin
                cv = nv;
                ca = na;
                cd = nd;
            end
        end

        ov = '0;
        for (int c = 0; c < CHANS; c++) begin
            ov[c]         = cv[RATIO*c];
            bus.o_addr[c] = ca[RATIO*c];
            bus.o_data[c] = cd[RATIO*c];
        end
        bus.o_valid = ov;
        bus.o_scb   = cs;
        stall       = |(ov & ~bus.i_out_ready);

        drops = '0;
        for (int l = 0; l < INPUTS; l++) begin
            if ((l % RATIO) != 0 && cv[l]) begin
                drops = drops + SUM_W'(1);
            end
        end
        sum = SUM_W'(cnt_q) + drops;
        if (stall) begin
            cnt_d = cnt_q;
        end else if (sum > CNT_MAX) begin
            cnt_d = {CNT_W{1'b1}};
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    assign bus.o_in_ready = ~stall;
    assign bus.o_drop_cnt = cnt_q;

    // Advance every enabled stage register together unless a sink stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s]   <= '0;
                a_q[s]   <= '0;
                d_q[s]   <= '0;
                scb_q[s] <= '0;
            end
            cnt_q <= '0;
        end else if (!stall) begin
            for (int s = 0; s < STAGES; s++) begin
                if (PIPE_MASK[s]) begin
                    v_q[s]   <= v_d[s];
                    a_q[s]   <= a_d[s];
                    d_q[s]   <= d_d[s];
                    scb_q[s] <= scb_d[s];
                end
            end
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_icon_utree_pipe.sv
// Directed bench for icon_utree_pipe: routing, latency, drops,
// saturation, backpressure, streaming against a butterfly model, reset.
module tb_icon_utree_pipe;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt0 = 0;

    always #5 clk = ~clk;

    icon_utree_pipe_if #(.CNT_W(16)) bus0 ();
    icon_utree_pipe_if #(.CNT_W(2))  bus1 ();
    icon_utree_pipe_if #(.CNT_W(16)) bus2 ();

    icon_utree_pipe #(
        .CHANS(4), .RATIO(4), .DATA_W(7), .ADDR_W(8),
        .PIPE_MASK(4'b0101), .CNT_W(16)
    ) u0 (.i_clk(clk), .i_rst(rst), .bus(bus0));

    icon_utree_pipe #(
        .CHANS(4), .RATIO(4), .DATA_W(7), .ADDR_W(8),
        .PIPE_MASK(4'b0101), .CNT_W(2)
    ) u1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

    icon_utree_pipe #(
        .CHANS(4), .RATIO(4), .DATA_W(7), .ADDR_W(8),
        .PIPE_MASK(4'b1111), .CNT_W(16)
    ) u2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.i_valid = '0;
        bus0.i_addr  = '0;
        bus0.i_data  = '0;
        bus0.i_scb   = '0;
    endtask

    task automatic idle_all();
        idle0();
        bus0.i_out_ready = '1;
        bus1.i_valid = '0;
        bus1.i_addr  = '0;
        bus1.i_data  = '0;
        bus1.i_scb   = '0;
        bus1.i_out_ready = '1;
        bus2.i_valid = '0;
        bus2.i_addr  = '0;
        bus2.i_data  = '0;
        bus2.i_scb   = '0;
        bus2.i_out_ready = '1;
    endtask

    // Golden butterfly: each lane gathers from its partner when the
    // node that owns the pair is crossed.
    task automatic route(
        input  logic [15:0]      v,
        input  logic [15:0][7:0] a,
        input  logic [15:0][6:0] d,
        input  logic [31:0]      w,
        output logic [15:0]      vo,
        output logic [15:0][7:0] ao,
        output logic [15:0][6:0] dout
    );
        logic [15:0]      tv;
        logic [15:0][7:0] ta;
        logic [15:0][6:0] td;
        int p;
        int lo;
        int n;
        vo = v;
        ao = a;
        dout = d;
        for (int s = 3; s >= 0; s--) begin
            for (int j = 0; j < 16; j++) begin
                p  = j ^ (1 << s);
                lo = (j < p) ? j : p;
                n  = ((lo >> (s + 1)) << s) | (lo & ((1 << s) - 1));
                if (w[s*8 + n]) begin
                    tv[j] = vo[p];
                    ta[j] = ao[p];
                    td[j] = dout[p];
                end else begin
                    tv[j] = vo[j];
                    ta[j] = ao[j];
                    td[j] = dout[j];
                end
            end
            vo = tv;
            ao = ta;
            dout = td;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        step();
        step();
        checks++;
        if (bus0.o_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_valid: got %b want 0000", bus0.o_valid);
        end
        checks++;
        if (bus0.o_scb !== 32'h0) begin
            errors++; $display("FAIL reset_scb: got %h want 0", bus0.o_scb);
        end
        checks++;
        if (bus0.o_drop_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", bus0.o_drop_cnt);
        end
        checks++;
        if (bus0.o_addr !== 32'h0) begin
            errors++; $display("FAIL reset_addr: got %h want 0", bus0.o_addr);
        end
        checks++;
        if (bus1.o_drop_cnt !== 2'd0) begin
            errors++; $display("FAIL reset_cnt1: got %0d want 0", bus1.o_drop_cnt);
        end
        checks++;
        if (bus2.o_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_valid2: got %b want 0000", bus2.o_valid);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_passthrough();
        bus0.i_valid   = 16'h0001;
        bus0.i_addr[0] = 8'hA5;
        bus0.i_data[0] = 7'h15;
        bus0.i_scb     = '0;
        checks++;
        if (bus0.o_in_ready !== 1'b1) begin
            errors++; $display("FAIL pass_ready: got %b want 1", bus0.o_in_ready);
        end
        step();
        idle0();
        checks++;
        if (bus0.o_valid !== 4'b0000) begin
            errors++; $display("FAIL pass_early: got %b want 0000", bus0.o_valid);
        end
        step();
        checks++;
        if (bus0.o_valid !== 4'b0001) begin
            errors++; $display("FAIL pass_valid: got %b want 0001", bus0.o_valid);
        end
        checks++;
        if (bus0.o_addr[0] !== 8'hA5) begin
            errors++; $display("FAIL pass_addr: got %h want a5", bus0.o_addr[0]);
        end
        checks++;
        if (bus0.o_data[0] !== 7'h15) begin
            errors++; $display("FAIL pass_data: got %h want 15", bus0.o_data[0]);
        end
        checks++;
        if (bus0.o_drop_cnt !== 16'(exp_cnt0)) begin
            errors++; $display("FAIL pass_cnt: got %0d want %0d", bus0.o_drop_cnt, exp_cnt0);
        end
        step();
        checks++;
        if (bus0.o_valid !== 4'b0000) begin
            errors++; $display("FAIL pass_once: got %b want 0000", bus0.o_valid);
        end
    endtask

    task automatic test_cross();
        logic [3:0][7:0] w;
        w = '0;
        w[1][1] = 1'b1;
        w[0][0] = 1'b1;
        bus0.i_valid   = 16'h0008;
        bus0.i_addr[3] = 8'h33;
        bus0.i_data[3] = 7'h2A;
        bus0.i_scb     = w;
        step();
        idle0();
        step();
        checks++;
        if (bus0.o_valid !== 4'b0001) begin
            errors++; $display("FAIL cross_valid: got %b want 0001", bus0.o_valid);
        end
        checks++;
        if (bus0.o_addr[0] !== 8'h33) begin
            errors++; $display("FAIL cross_addr: got %h want 33", bus0.o_addr[0]);
        end
        checks++;
        if (bus0.o_data[0] !== 7'h2A) begin
            errors++; $display("FAIL cross_data: got %h want 2a", bus0.o_data[0]);
        end
        checks++;
        if (bus0.o_scb !== w) begin
            errors++; $display("FAIL cross_scb: got %h want %h", bus0.o_scb, w);
        end
        step();
    endtask

    task automatic test_drops();
        bus0.i_valid = 16'h0006;
        bus0.i_scb   = '0;
        step();
        idle0();
        step();
        checks++;
        if (bus0.o_valid !== 4'b0000) begin
            errors++; $display("FAIL drop_valid: got %b want 0000", bus0.o_valid);
        end
        checks++;
        if (bus0.o_drop_cnt !== 16'(exp_cnt0)) begin
            errors++; $display("FAIL drop_cnt_pre: got %0d want %0d", bus0.o_drop_cnt, exp_cnt0);
        end
        step();
        exp_cnt0 += 2;
        checks++;
        if (bus0.o_drop_cnt !== 16'(exp_cnt0)) begin
            errors++; $display("FAIL drop_cnt: got %0d want %0d", bus0.o_drop_cnt, exp_cnt0);
        end
    endtask

    task automatic test_drop_saturate();
        logic [1:0] want [4];
        want = '{2'd2, 2'd3, 2'd3, 2'd3};
        bus1.i_valid = 16'h0006;
        bus1.i_scb   = '0;
        step();
        step();
        step();
        bus1.i_valid = '0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus1.o_drop_cnt !== want[k]) begin
                errors++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, bus1.o_drop_cnt, want[k]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        bus0.i_out_ready = 4'b1110;
        bus0.i_valid   = 16'h0021;
        bus0.i_addr[0] = 8'h11;
        bus0.i_data[0] = 7'h01;
        bus0.i_addr[5] = 8'h55;
        bus0.i_scb     = '0;
        step();
        bus0.i_valid   = 16'h0001;
        bus0.i_addr[0] = 8'h22;
        bus0.i_data[0] = 7'h02;
        bus0.i_addr[5] = 8'h00;
        step();
        idle0();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus0.o_in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready%0d: got %b want 0", k, bus0.o_in_ready);
            end
            checks++;
            if (bus0.o_valid !== 4'b0001 || bus0.o_addr[0] !== 8'h11) begin
                errors++; $display("FAIL bp_hold%0d: got %b/%h want 0001/11", k, bus0.o_valid, bus0.o_addr[0]);
            end
            checks++;
            if (bus0.o_drop_cnt !== 16'(exp_cnt0)) begin
                errors++; $display("FAIL bp_cnt%0d: got %0d want %0d", k, bus0.o_drop_cnt, exp_cnt0);
            end
            step();
        end
        bus0.i_out_ready = 4'b1111;
        #1;
        checks++;
        if (bus0.o_in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got %b want 1", bus0.o_in_ready);
        end
        step();
        exp_cnt0 += 1;
        checks++;
        if (bus0.o_valid !== 4'b0001 || bus0.o_addr[0] !== 8'h22 || bus0.o_data[0] !== 7'h02) begin
            errors++; $display("FAIL bp_next: got %b/%h/%h want 0001/22/02", bus0.o_valid, bus0.o_addr[0], bus0.o_data[0]);
        end
        checks++;
        if (bus0.o_drop_cnt !== 16'(exp_cnt0)) begin
            errors++; $display("FAIL bp_cnt_rel: got %0d want %0d", bus0.o_drop_cnt, exp_cnt0);
        end
        step();
        checks++;
        if (bus0.o_valid !== 4'b0000 || bus0.o_drop_cnt !== 16'(exp_cnt0)) begin
            errors++; $display("FAIL bp_drain: got %b/%0d want 0000/%0d", bus0.o_valid, bus0.o_drop_cnt, exp_cnt0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]      words [8];
        logic [15:0]      iv [8];
        logic [15:0][7:0] ia [8];
        logic [15:0][6:0] id [8];
        logic [15:0]      ev [8];
        logic [15:0][7:0] ea [8];
        logic [15:0][6:0] ed [8];
        logic [3:0]       wv;
        int exp2;
        int k;
        words = '{32'h00000000, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h12345678,
                  32'hA5A5A5A5, 32'h80000001, 32'h00FF00FF, 32'hC3C3C3C3};
        exp2 = 0;
        for (int b = 0; b < 8; b++) begin
            iv[b] = 16'hFFFF ^ (16'h0001 << (2 * b));
            for (int l = 0; l < 16; l++) begin
                ia[b][l] = {4'(b), 4'(l)};
                id[b][l] = 7'(l * 5 + b * 3);
            end
            route(iv[b], ia[b], id[b], words[b], ev[b], ea[b], ed[b]);
            for (int l = 0; l < 16; l++) begin
                if ((l % 4) != 0 && ev[b][l]) exp2++;
            end
        end
        for (int c = 0; c <= 12; c++) begin
            if (c >= 4 && c < 12) begin
                k = c - 4;
                wv = {ev[k][12], ev[k][8], ev[k][4], ev[k][0]};
                checks++;
                if (bus2.o_valid !== wv) begin
                    errors++; $display("FAIL b2b_valid%0d: got %b want %b", k, bus2.o_valid, wv);
                end
                checks++;
                if (bus2.o_scb !== words[k]) begin
                    errors++; $display("FAIL b2b_scb%0d: got %h want %h", k, bus2.o_scb, words[k]);
                end
                for (int ch = 0; ch < 4; ch++) begin
                    if (wv[ch]) begin
                        checks++;
                        if (bus2.o_addr[ch] !== ea[k][4*ch] || bus2.o_data[ch] !== ed[k][4*ch]) begin
                            errors++;
                            $display("FAIL b2b_lane%0d_%0d: got %h/%h want %h/%h", k, ch,
                                     bus2.o_addr[ch], bus2.o_data[ch], ea[k][4*ch], ed[k][4*ch]);
                        end
                    end
                end
            end else begin
                checks++;
                if (bus2.o_valid !== 4'b0000) begin
                    errors++; $display("FAIL b2b_empty%0d: got %b want 0000", c, bus2.o_valid);
                end
            end
            if (c == 12) begin
                checks++;
                if (bus2.o_drop_cnt !== 16'(exp2)) begin
                    errors++; $display("FAIL b2b_cnt: got %0d want %0d", bus2.o_drop_cnt, exp2);
                end
            end
            if (c < 8) begin
                bus2.i_valid = iv[c];
                bus2.i_addr  = ia[c];
                bus2.i_data  = id[c];
                bus2.i_scb   = words[c];
            end else begin
                bus2.i_valid = '0;
                bus2.i_scb   = '0;
            end
            step();
        end
    endtask

    task automatic test_reset_midstream();
        bus0.i_valid   = 16'h0003;
        bus0.i_addr[0] = 8'h77;
        bus0.i_data[0] = 7'h07;
        bus0.i_scb     = 32'h80000000;
        step();
        idle0();
        bus0.i_valid   = 16'h0010;
        bus0.i_addr[4] = 8'h44;
        step();
        idle0();
        checks++;
        if (bus0.o_valid !== 4'b0001 || bus0.o_scb !== 32'h80000000) begin
            errors++; $display("FAIL rst_pre: got %b/%h want 0001/80000000", bus0.o_valid, bus0.o_scb);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus0.o_valid !== 4'b0000) begin
            errors++; $display("FAIL rst_valid: got %b want 0000", bus0.o_valid);
        end
        checks++;
        if (bus0.o_scb !== 32'h0) begin
            errors++; $display("FAIL rst_scb: got %h want 0", bus0.o_scb);
        end
        checks++;
        if (bus0.o_drop_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_cnt: got %0d want 0", bus0.o_drop_cnt);
        end
        rst = 1'b0;
        exp_cnt0 = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (bus0.o_valid !== 4'b0000 || bus0.o_drop_cnt !== 16'(exp_cnt0)) begin
                errors++; $display("FAIL rst_flush%0d: got %b/%0d want 0000/0", k, bus0.o_valid, bus0.o_drop_cnt);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_cross();
        test_drops();
        test_drop_saturate();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
